// File: rtl/branch_predictor.sv
// branch_predictor
//   Bimodal branch-direction predictor. A table of ENTRIES 2-bit saturating
//   counters is indexed by pc[IDX+1:2]. After reset the table is swept to
//   2'b01 (weakly not-taken), one entry per cycle, before lookups and
//   updates are accepted. Lookups return the counter MSB one cycle later.
//   Execute-stage updates train the counter and feed two saturating
//   performance counters (branches seen, mispredictions).
//
// Ports
//   clock            single clock, rising edge
//   reset            synchronous, active-low
//   io_ready         table initialised, lookups/updates accepted
//   io_req_valid     lookup request
//   io_req_pc        lookup PC
//   io_resp_valid    prediction valid (one cycle after accepted request)
//   io_resp_taken    predicted direction (holds when no response)
//   io_upd_valid     resolved-branch update
//   io_upd_pc        PC of the resolved branch
//   io_upd_br_type   branch type, 1..6 are branches, 0 and 7 are not
//   io_upd_taken     resolved outcome
//   io_upd_pred      prediction that was used
//   io_num_branches  saturating count of accepted updates
//   io_num_mispred   saturating count of accepted mispredicted updates
//   dbg_state        FSM state (0 = INIT, 1 = READY)
//
// Handshake: there is no back-pressure. A lookup is accepted on any rising
// edge where io_ready and io_req_valid are both high; its response is shown
// with io_resp_valid for exactly the following cycle. An update is accepted
// on any rising edge where io_ready, io_upd_valid are high and the branch
// type is 1..6; anything offered while io_ready is low is dropped.

module branch_predictor #(
  parameter int ENTRIES = 64,
  localparam int IDX = $clog2(ENTRIES)
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_ready,
  input  logic        io_req_valid,
  input  logic [31:0] io_req_pc,
  output logic        io_resp_valid,
  output logic        io_resp_taken,
  input  logic        io_upd_valid,
  input  logic [31:0] io_upd_pc,
  input  logic [2:0]  io_upd_br_type,
  input  logic        io_upd_taken,
  input  logic        io_upd_pred,
  output logic [31:0] io_num_branches,
  output logic [31:0] io_num_mispred,
  output logic        dbg_state
);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDX-1:0] init_idx;
  logic [1:0]     table_q [ENTRIES];

  logic [IDX-1:0] req_idx;
  logic [IDX-1:0] upd_idx;
  logic           is_branch;
  logic           upd_accept;
  logic           req_accept;
  logic [1:0]     ctr_cur;
  logic [1:0]     ctr_next;

  // PC bits outside the index field are intentionally not used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{io_req_pc[31:IDX+2], io_req_pc[1:0],
                            io_upd_pc[31:IDX+2], io_upd_pc[1:0]};

  assign req_idx    = io_req_pc[IDX+1:2];
  assign upd_idx    = io_upd_pc[IDX+1:2];
  assign is_branch  = (io_upd_br_type != 3'd0) && (io_upd_br_type != 3'd7);
  assign req_accept = (state_q == READY) && io_req_valid;
  assign upd_accept = (state_q == READY) && io_upd_valid && is_branch;
  assign ctr_cur    = table_q[upd_idx];

  // Saturating 2-bit counter step.
  always_comb begin
    ctr_next = ctr_cur;
    if (io_upd_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  // FSM next state and state-derived outputs.
  always_comb begin
    state_d   = state_q;
    io_ready  = 1'b0;
    dbg_state = state_q;
    case (state_q)
      INIT: begin
        if (init_idx == IDX'(ENTRIES - 1)) state_d = READY;
      end
      READY: begin
        io_ready = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Sweep index wraps to 0 after the last entry, which is harmless because
  // it is only consulted in INIT.
  always_ff @(posedge clock) begin
    if (!reset)                init_idx <= '0;
    else if (state_q == INIT)  init_idx <= init_idx + 1'b1;
  end

  // Table has no reset of its own; the INIT sweep initialises it, and all
  // writes are held off while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == INIT)  table_q[init_idx] <= 2'b01;
      else if (upd_accept)  table_q[upd_idx]  <= ctr_next;
    end
  end

  // Response reads the table before this edge's update is applied, which
  // gives read-before-write on a same-index collision.
  always_ff @(posedge clock) begin
    if (!reset) begin
      io_resp_valid <= 1'b0;
      io_resp_taken <= 1'b0;
    end else if (req_accept) begin
      io_resp_valid <= 1'b1;
      io_resp_taken <= table_q[req_idx][1];
    end else begin
      io_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      io_num_branches <= '0;
      io_num_mispred  <= '0;
    end else if (upd_accept) begin
      if (io_num_branches != 32'hFFFF_FFFF)
        io_num_branches <= io_num_branches + 32'd1;
      if ((io_upd_pred != io_upd_taken) && (io_num_mispred != 32'hFFFF_FFFF))
        io_num_mispred <= io_num_mispred + 32'd1;
    end
  end

endmodule
